// File: rtl/alu_writeback_pkg.sv
// Shared types and constants for the ALU writeback stage.
// Optional feature macro: ALU_WB_FWD_EN (write-to-read forwarding).
package alu_writeback_pkg;

    localparam int DATA_W     = 20;
    localparam int REG_CNT    = 16;
    localparam int ADDR_W     = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int FLAG_W     = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] dest;
        logic              wr_en;
        logic              flag_en;
        logic [FLAG_W-1:0] flags;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_fifo.sv
// Two-entry FIFO buffering ALU results awaiting the shared write port.
// Push is ignored when full and pop when empty.
module alu_writeback_fifo
    import alu_writeback_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  logic      pop_i,
    input  wb_entry_t entry_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o,
    output logic [1:0] count_o
);

    wb_entry_t  mem_q [FIFO_DEPTH];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       push_ok;
    logic       pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: result FIFO, load-priority write arbitration,
// 16x20 register file and flags. Macro ALU_WB_FWD_EN enables forwarding.
module alu_writeback
    import alu_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_wr_en,
    input  logic              in_flag_en,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_dest,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [FLAG_W-1:0] flags,
    output logic [1:0]        pending
);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [FLAG_W-1:0] flags_q;

    wb_entry_t   in_entry;
    wb_entry_t   head;
    wb_entry_t   commit;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  fifo_count;
    logic        xfer;
    logic        push;
    logic        pop;
    logic        commit_v;
    logic        we;
    logic        wr_hit;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    assign in_entry = '{data: in_data, dest: in_dest, wr_en: in_wr_en,
                        flag_en: in_flag_en, flags: in_flags};
    assign in_ready = !fifo_full && !rst;
    assign xfer     = in_valid && in_ready;
    assign pending  = fifo_count;
    assign flags    = flags_q;

    alu_writeback_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .entry_i (in_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Load wins the port; an empty FIFO lets the incoming result bypass.
    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        commit   = '0;
        commit_v = 1'b0;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        if (ld_valid) begin
            we    = 1'b1;
            waddr = ld_dest;
            wdata = ld_data;
            push  = xfer;
        end else if (!fifo_empty) begin
            pop      = 1'b1;
            commit   = head;
            commit_v = 1'b1;
            push     = xfer;
        end else if (xfer) begin
            commit   = in_entry;
            commit_v = 1'b1;
        end
        if (commit_v) begin
            we    = commit.wr_en;
            waddr = commit.dest;
            wdata = commit.data;
        end
    end

    assign wr_hit = we && (waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
            flags_q <= '0;
        end else begin
            if (wr_hit) begin
                regs_q[waddr] <= wdata;
            end
            if (commit_v && commit.flag_en) begin
                flags_q <= commit.flags;
            end
        end
    end

`ifdef ALU_WB_FWD_EN
    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
        rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
        if (wr_hit && (waddr == rd_addr_a)) begin
            rd_data_a = wdata;
        end
        if (wr_hit && (waddr == rd_addr_b)) begin
            rd_data_b = wdata;
        end
    end
`else
    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
`endif

endmodule
